video_line_buffer: RTL and testbench
====================================

Name: video_line_buffer

Overview:
- Ping-pong line buffer between the display pixel fetch/decode path and the video timing generator.
- The producer fills one bank with the next line's RGB pixels while the other bank drains on the timing generator's new_pixel strobes.
- Banks swap on new_line.
- Outputs pixel data together with hsync/vsync/hblank/vblank delayed by the same pipeline depth, so the video output stage sees aligned data.

Parameters:
- DATA_W, 24, pixel width (8:8:8 RGB).
- DEPTH, 768, pixels per bank; covers the widest line (hires 768).
- ADDR_W, 10, bank address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock (same as timing generator)
- reset  in  1  asynchronous, active-high reset
- new_frame  in  1  one-clock pulse from timing generator, start of frame
- new_line  in  1  one-clock pulse from timing generator, start of line
- new_pixel  in  1  pixel strobe from timing generator (already gated by blanking)
- hsync_in, vsync_in, hblank_in, vblank_in  in  1 each  timing signals to be realigned
- wr_valid  in  1  producer pixel valid
- wr_ready  out  1  buffer can accept a pixel
- wr_data  in  DATA_W  producer pixel
- wr_last  in  1  marks final pixel of the line (qualified by wr_valid)
- line_req  out  1  one-clock pulse: producer must start filling the next line
- pix_data  out  DATA_W  output pixel; 0 when not valid
- pix_valid  out  1  pix_data carries a buffered pixel
- hsync, vsync, hblank, vblank  out  1 each  inputs delayed 1 clk
- underrun  out  1  sticky: a swap found the fill bank incomplete, or a read ran past stored count; cleared by new_frame

Behaviour:
- Reset (async) values:
  - fill_bank=0, disp_bank=1, fill_cnt=0, fill_done=0, disp_cnt=0, rd_ptr=0.
  - All outputs 0, except hblank=1 and vblank=1.
- Write side:
  - wr_ready = !fill_done && fill_cnt < DEPTH.
  - On wr_valid && wr_ready: mem[fill_bank][fill_cnt] <= wr_data; fill_cnt++.
  - fill_done is set (registered) when the accepted beat has wr_last=1, or when fill_cnt reaches DEPTH.
  - wr_data is ignored while wr_ready=0.
- Swap on new_line, when not coincident with new_frame:
  - If fill_done (registered value): disp_bank<=fill_bank, fill_bank<=disp_bank, disp_cnt<=fill_cnt, fill_cnt<=0, fill_done<=0, rd_ptr<=0; line_req pulses the next cycle.
  - If not fill_done: no swap; disp_cnt<=0 so the whole line outputs zeros; rd_ptr<=0; underrun<=1. Filling continues and line_req is not re-issued.
  - A last beat accepted in the same cycle as new_line does not count for that swap. It swaps on the following new_line.
- new_frame has priority over new_line in the same cycle:
  - Flush: fill_cnt=0, fill_done=0, disp_cnt=0, rd_ptr=0, underrun<=0.
  - Banks keep their roles; line_req pulses the next cycle.
  - A write beat in that cycle is discarded.
- Read side, pipeline latency exactly 1 clk from new_pixel:
  - On new_pixel with rd_ptr < disp_cnt: the next cycle pix_valid=1 and pix_data=mem[disp_bank][rd_ptr]; rd_ptr++.
  - On new_pixel with rd_ptr >= disp_cnt: the next cycle pix_valid=0 and pix_data=0. Set underrun only if disp_cnt!=0 (a short line); a zero-count line already flagged.
  - Without new_pixel: pix_valid=0, pix_data=0.
- hsync/vsync/hblank/vblank are registered copies of the *_in signals (1 clk), aligned with pix_data.
- Memory: two DEPTH x DATA_W banks in a single inferred simple dual-port RAM (one write port, one registered read port), addressed {bank, ptr}.
- Reads and writes always target different banks, so there is no read/write collision.

Decomposition:
- Shared package video_pkg:
  - rgb888_t packed struct (r, g, b, 8 bits each).
  - Constant MAX_LINE_PIXELS=768.
- One sub-module: line_buffer_ram, a dual-port RAM with registered read, parameterised on DATA_W and address width ADDR_W+1.
- Control stays in video_line_buffer.

Test Plan:
- Fill and drain:
  - After reset and new_frame, the bench sees line_req.
  - Write 384 pixels 0x000001..0x000180 with wr_last on the 384th, then new_line, then 384 new_pixel strobes.
  - Required: pix_valid 1 clk after each strobe, data in order 0x000001..0x000180, underrun=0, line_req 1 clk after new_line.
- Underrun:
  - Write only 100 pixels with no wr_last, then new_line.
  - Required: no swap, underrun=1, pix_data=0 and pix_valid=0 for every strobe on that line.
- Short line:
  - Write 10 pixels with wr_last, new_line, then 12 strobes.
  - Required: 10 valid pixels, then 2 zero outputs; underrun goes 1 on the 11th strobe.
- Overflow:
  - Hold wr_valid for 800 beats with no wr_last.
  - Required: wr_ready drops after the 768th accepted beat; fill_done set; next new_line swaps with disp_cnt=768.
- Simultaneous events:
  - Case A: wr_last accepted in the same cycle as new_line. Required: no swap, underrun=1; swap happens on the next new_line.
  - Case B: new_frame and new_line together. Required: flush wins, underrun cleared.
- Async reset mid-line:
  - Assert reset during draining.
  - Required: outputs immediately 0 (hblank/vblank 1) and wr_ready=0; after release, the sequence restarts cleanly from new_frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video types and constants for the display output path.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int MAX_LINE_PIXELS = 768;
  localparam int RGB_W           = $bits(rgb888_t);

  // Buffer is inert after reset until the first new_frame arms it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lb_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module line_buffer_ram #(
  parameter int DATA_W = 24,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/video_line_buffer.sv
// Ping-pong line buffer: producer fills one bank while the other drains on
// new_pixel; banks swap on new_line; timing signals re-aligned to pixel data.
module video_line_buffer
  import video_pkg::*;
#(
  parameter int DATA_W = RGB_W,
  parameter int DEPTH  = MAX_LINE_PIXELS,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              new_line,
  input  logic              new_pixel,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              line_req,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              underrun
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  lb_state_e         state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  logic              disp_bank_q, disp_bank_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              fill_done_q, fill_done_d;
  logic [CNT_W-1:0]  disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              underrun_q, underrun_d;
  logic              line_req_q, line_req_d;
  logic              pix_valid_q, pix_valid_d;
  logic              hsync_q, vsync_q, hblank_q, vblank_q;

  logic              active, wr_fire, swap_ok, swap_fail, rd_hit, rd_short;
  logic [DATA_W-1:0] ram_rd_data;

  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    disp_bank_d = disp_bank_q;
    fill_cnt_d  = fill_cnt_q;
    fill_done_d = fill_done_q;
    disp_cnt_d  = disp_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    underrun_d  = underrun_q;
    line_req_d  = 1'b0;

    active    = (state_q == ST_RUN);
    wr_ready  = active && !fill_done_q && (fill_cnt_q < DEPTH_C);
    wr_fire   = wr_valid && wr_ready && !new_frame;
    // Only the registered fill_done decides a swap; a last beat in the same
    // cycle as new_line is held over to the following line.
    swap_ok   = active && new_line && !new_frame && fill_done_q;
    swap_fail = active && new_line && !new_frame && !fill_done_q;
    rd_hit    = active && new_pixel && !new_frame && (rd_ptr_q < disp_cnt_q);
    rd_short  = active && new_pixel && !new_frame && !rd_hit && (disp_cnt_q != '0);
    pix_valid_d = rd_hit;

    if (wr_fire) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
      if (wr_last || (fill_cnt_q + 1'b1 == DEPTH_C)) fill_done_d = 1'b1;
    end
    if (rd_hit)   rd_ptr_d   = rd_ptr_q + 1'b1;
    if (rd_short) underrun_d = 1'b1;

    if (new_frame) begin
      state_d    = ST_RUN;
      fill_cnt_d  = '0;
      fill_done_d = 1'b0;
      disp_cnt_d  = '0;
      rd_ptr_d    = '0;
      underrun_d  = 1'b0;
      line_req_d  = 1'b1;
    end else if (swap_ok) begin
      fill_bank_d = disp_bank_q;
      disp_bank_d = fill_bank_q;
      disp_cnt_d  = fill_cnt_q;
      fill_cnt_d  = '0;
      fill_done_d = 1'b0;
      rd_ptr_d    = '0;
      line_req_d  = 1'b1;
    end else if (swap_fail) begin
      disp_cnt_d = '0;
      rd_ptr_d   = '0;
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fill_bank_q <= 1'b0;
      disp_bank_q <= 1'b1;
      fill_cnt_q  <= '0;
      fill_done_q <= 1'b0;
      disp_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      underrun_q  <= 1'b0;
      line_req_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      disp_bank_q <= disp_bank_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_done_q <= fill_done_d;
      disp_cnt_q  <= disp_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      underrun_q  <= underrun_d;
      line_req_q  <= line_req_d;
      pix_valid_q <= pix_valid_d;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      hblank_q    <= hblank_in;
      vblank_q    <= vblank_in;
    end
  end

  line_buffer_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({fill_bank_q, fill_cnt_q[ADDR_W-1:0]}),
    .wr_data (wr_data),
    .rd_en   (rd_hit),
    .rd_addr ({disp_bank_q, rd_ptr_q[ADDR_W-1:0]}),
    .rd_data (ram_rd_data)
  );

  // RAM output holds stale data between reads; mask it outside valid beats.
  assign pix_data  = pix_valid_q ? ram_rd_data : '0;
  assign pix_valid = pix_valid_q;
  assign line_req  = line_req_q;
  assign underrun  = underrun_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblank    = hblank_q;
  assign vblank    = vblank_q;

endmodule

// File: tb/tb_video_line_buffer.sv
// Directed bench for video_line_buffer: fill/drain, underrun, short line,
// overflow, coincident events and asynchronous reset.
module tb_video_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_frame, new_line, new_pixel;
  logic        hsync_in, vsync_in, hblank_in, vblank_in;
  logic        wr_valid, wr_ready, wr_last;
  logic [23:0] wr_data;
  logic        line_req;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        hsync, vsync, hblank, vblank;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_line_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .new_frame (new_frame),
    .new_line  (new_line),
    .new_pixel (new_pixel),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblank_in (hblank_in),
    .vblank_in (vblank_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .line_req  (line_req),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank),
    .underrun  (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pixels(input int n, input logic [23:0] base, input bit last,
                              output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 24'(i);
      wr_last  = last && (i == n - 1);
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
  endtask

  task automatic pulse_line(input logic exp_req, input logic exp_ur, input string tag);
    new_line = 1'b1;
    step();
    new_line = 1'b0;
    check({tag, "_line_req"}, 32'(line_req), 32'(exp_req));
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_ur));
  endtask

  task automatic pulse_frame(input string tag);
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    check({tag, "_line_req"}, 32'(line_req), 32'd1);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  // Strobe i yields base+i while i < nvalid, else zero; underrun expected from ur_at on.
  task automatic drain(input int n, input logic [23:0] base, input int nvalid,
                       input int ur_at, input string tag);
    for (int i = 0; i < n; i++) begin
      new_pixel = 1'b1;
      step();
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'(i < nvalid));
      check({tag, "_pix_data"}, 32'(pix_data), (i < nvalid) ? 32'(base + 24'(i)) : 32'd0);
      check({tag, "_underrun"}, 32'(underrun), 32'(i >= ur_at));
    end
    new_pixel = 1'b0;
    step();
    check({tag, "_idle_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_idle_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    int acc;
    reset = 1'b1;
    {new_frame, new_line, new_pixel} = '0;
    {hsync_in, vsync_in, hblank_in, vblank_in} = '0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    $display("reset values");
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_hblank", 32'(hblank), 32'd1);
    check("rst_vblank", 32'(vblank), 32'd1);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_line_req", 32'(line_req), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    step();
    check("idle_wr_ready", 32'(wr_ready), 32'd0);

    $display("fill and drain 384 pixels");
    pulse_frame("frame0");
    check("frame0_wr_ready", 32'(wr_ready), 32'd1);
    step();
    check("frame0_req_pulse", 32'(line_req), 32'd0);
    write_pixels(384, 24'h000001, 1'b1, acc);
    check("fill384_acc", 32'(acc), 32'd384);
    check("fill384_ready_low", 32'(wr_ready), 32'd0);
    pulse_line(1'b1, 1'b0, "swap1");
    check("swap1_ready", 32'(wr_ready), 32'd1);
    drain(384, 24'h000001, 384, 100000, "line1");

    $display("timing passthrough");
    hsync_in = 1'b1; vblank_in = 1'b0;
    step();
    check("sync_hsync", 32'(hsync), 32'd1);
    check("sync_vblank", 32'(vblank), 32'd0);
    hsync_in = 1'b0;
    step();
    check("sync_hsync_fall", 32'(hsync), 32'd0);

    $display("underrun: 100 pixels, no wr_last");
    write_pixels(100, 24'h00AA00, 1'b0, acc);
    check("part_acc", 32'(acc), 32'd100);
    pulse_line(1'b0, 1'b1, "noswap");
    drain(5, 24'h0, 0, 0, "zero_line");
    pulse_frame("frame1");

    $display("short line: 10 pixels, 12 strobes");
    write_pixels(10, 24'h000100, 1'b1, acc);
    check("short_ready_low", 32'(wr_ready), 32'd0);
    pulse_line(1'b1, 1'b0, "short_swap");
    drain(12, 24'h000100, 10, 10, "short");

    $display("overflow: 800 beats, no wr_last");
    write_pixels(800, 24'h200000, 1'b0, acc);
    check("ovf_acc", 32'(acc), 32'd768);
    check("ovf_ready_low", 32'(wr_ready), 32'd0);
    pulse_line(1'b1, 1'b1, "ovf_swap");
    drain(769, 24'h200000, 768, 0, "ovf");

    $display("case A: wr_last with new_line");
    pulse_frame("frameA");
    write_pixels(4, 24'h000300, 1'b0, acc);
    wr_valid = 1'b1; wr_data = 24'h000304; wr_last = 1'b1; new_line = 1'b1;
    check("caseA_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0; wr_last = 1'b0; new_line = 1'b0;
    check("caseA_line_req", 32'(line_req), 32'd0);
    check("caseA_underrun", 32'(underrun), 32'd1);
    check("caseA_done_ready", 32'(wr_ready), 32'd0);
    pulse_line(1'b1, 1'b1, "caseA_swap");
    drain(6, 24'h000300, 5, 0, "caseA");

    $display("case B: new_frame with new_line");
    pulse_frame("frameB0");
    write_pixels(3, 24'h000400, 1'b1, acc);
    new_frame = 1'b1; new_line = 1'b1;
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = 24'h0004FF;
    step();
    {new_frame, new_line, wr_valid, wr_last} = '0;
    check("caseB_line_req", 32'(line_req), 32'd1);
    check("caseB_underrun", 32'(underrun), 32'd0);
    check("caseB_ready", 32'(wr_ready), 32'd1);
    step();
    pulse_line(1'b0, 1'b1, "caseB_after");
    drain(2, 24'h0, 0, 0, "caseB");

    $display("async reset mid-line");
    pulse_frame("frameR");
    write_pixels(20, 24'h000500, 1'b1, acc);
    pulse_line(1'b1, 1'b0, "rswap");
    hsync_in = 1'b1; vsync_in = 1'b1; hblank_in = 1'b0; vblank_in = 1'b0;
    drain(5, 24'h000500, 20, 100000, "pre_rst");
    check("pre_rst_hblank", 32'(hblank), 32'd0);
    new_pixel = 1'b1;
    step();
    check("pre_rst_valid", 32'(pix_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 32'd0);
    check("arst_pix_data", 32'(pix_data), 32'd0);
    check("arst_hsync", 32'(hsync), 32'd0);
    check("arst_vsync", 32'(vsync), 32'd0);
    check("arst_hblank", 32'(hblank), 32'd1);
    check("arst_vblank", 32'(vblank), 32'd1);
    check("arst_wr_ready", 32'(wr_ready), 32'd0);
    #1 reset = 1'b0;
    new_pixel = 1'b0;
    step();
    check("post_rst_ready", 32'(wr_ready), 32'd0);
    check("post_rst_valid", 32'(pix_valid), 32'd0);
    pulse_frame("frameR2");
    write_pixels(8, 24'h000600, 1'b1, acc);
    check("restart_acc", 32'(acc), 32'd8);
    pulse_line(1'b1, 1'b0, "restart_swap");
    drain(9, 24'h000600, 8, 8, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
